// File: rtl/tinyqv_uart_pkg.sv
// Shared definitions for the TinyQV debug UART: receiver state encoding
// and the bit-timing derivation used by both transmitter and receiver.
package tinyqv_uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } uart_rx_state_e;

  // Clock cycles spent on one serial bit.
  function automatic int unsigned cycles_per_bit(input int unsigned clk_hz,
                                                 input int unsigned bit_rate);
    return clk_hz / bit_rate;
  endfunction

  // Offset from a bit edge to its middle.
  function automatic int unsigned half_bit(input int unsigned clk_hz,
                                           input int unsigned bit_rate);
    return cycles_per_bit(clk_hz, bit_rate) / 2;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous FIFO holding received bytes. Push and pop may happen on
// the same edge; a push into a full FIFO is accepted only alongside a pop.
module uart_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_pop;
  logic             w_do_push;

  assign empty     = (r_count == '0);
  assign full      = (r_count == FULL_COUNT);
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);
  assign head      = empty ? '0 : r_mem[r_rd_ptr];
  assign count     = r_count;

  // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage write port.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset; empty entries are
    // never visible because head is forced to zero while the FIFO is empty.
    if (w_do_push) r_mem[r_wr_ptr] <= push_data;
  end

endmodule

// File: rtl/debug_uart_rx.sv
// Debug UART receiver: 8N1, LSB first, mid-bit sampling from a 2-flop
// synchronised input, with a small receive FIFO and sticky error flags.
module debug_uart_rx
  import tinyqv_uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 25_000_000,
  parameter int unsigned BIT_RATE   = 1_000_000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          uart_rxd,
  input  logic                          rx_pop,
  input  logic                          err_clear,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count,
  output logic                          rx_busy,
  output logic                          frame_err,
  output logic                          overrun,
  output logic                          rx_irq
);

  localparam int unsigned CYCLES_PER_BIT = cycles_per_bit(CLK_HZ, BIT_RATE);
  localparam int unsigned HALF_BIT       = half_bit(CLK_HZ, BIT_RATE);
  localparam int          DIV_W          = $clog2(CYCLES_PER_BIT);

  uart_rx_state_e r_state;
  uart_rx_state_e w_state_next;
  logic             r_sync1;
  logic             r_rxd_s;
  logic [DIV_W-1:0] r_div;
  logic [2:0]       r_bit_cnt;
  logic [7:0]       r_shift;
  logic             r_frame_err;
  logic             r_overrun;

  logic             w_tick_half;
  logic             w_tick_full;
  logic             w_div_clr;
  logic             w_shift_en;
  logic             w_push;
  logic             w_frame_set;
  logic             w_overrun_set;
  logic             w_fifo_full;
  logic             w_fifo_empty;

  assign w_tick_half   = (r_div == DIV_W'(HALF_BIT - 1));
  assign w_tick_full   = (r_div == DIV_W'(CYCLES_PER_BIT - 1));
  // Full implies non-empty, so any pop this edge frees the slot.
  assign w_overrun_set = w_push && w_fifo_full && !rx_pop;

  // Two-flop synchroniser; idles high so reset does not look like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_rxd_s <= 1'b1;
    end else begin
      r_sync1 <= uart_rxd;
      r_rxd_s <= r_sync1;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state and per-cycle strobes for the frame decoder.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    w_state_next = r_state;
    w_div_clr    = 1'b0;
    w_shift_en   = 1'b0;
    w_push       = 1'b0;
    w_frame_set  = 1'b0;
    case (r_state)
      IDLE: begin
        w_div_clr = 1'b1;
        if (!r_rxd_s) w_state_next = START;
      end
      START: begin
        if (w_tick_half) begin
          w_div_clr    = 1'b1;
          w_state_next = r_rxd_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (w_tick_full) begin
          w_div_clr  = 1'b1;
          w_shift_en = 1'b1;
          if (r_bit_cnt == 3'd7) w_state_next = STOP;
        end
      end
      STOP: begin
        if (w_tick_full) begin
          w_div_clr = 1'b1;
          if (r_rxd_s) begin
            w_push       = 1'b1;
            w_state_next = IDLE;
          end else begin
            w_frame_set  = 1'b1;
            w_state_next = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        // A held-low line (break) yields a single frame error.
        w_div_clr = 1'b1;
        if (r_rxd_s) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Bit-period divider, data bit counter and LSB-first shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div     <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else begin
      r_div <= w_div_clr ? '0 : r_div + 1'b1;
      if (r_state == IDLE)  r_bit_cnt <= '0;
      else if (w_shift_en)  r_bit_cnt <= r_bit_cnt + 1'b1;
      if (w_shift_en) r_shift <= {r_rxd_s, r_shift[7:1]};
    end
  end

  // Sticky error flags; a new error event wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_frame_set)    r_frame_err <= 1'b1;
      else if (err_clear) r_frame_err <= 1'b0;
      if (w_overrun_set)  r_overrun   <= 1'b1;
      else if (err_clear) r_overrun   <= 1'b0;
    end
  end

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_data (r_shift),
    .pop       (rx_pop),
    .head      (rx_data),
    .count     (rx_count),
    .full      (w_fifo_full),
    .empty     (w_fifo_empty)
  );

  assign rx_valid  = !w_fifo_empty;
  assign rx_busy   = (r_state != IDLE);
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;
  assign rx_irq    = rx_valid | r_frame_err | r_overrun;

endmodule

// File: tb/tb_debug_uart_rx.sv
// Testbench for debug_uart_rx: directed frames against a queue-based model
// of the receive FIFO and flags, checked every cycle, plus literal checks.
module tb_debug_uart_rx;

  localparam int CPB      = 25;
  localparam int PUSH_LAT = 240;  // start-edge to FIFO-visible result
  localparam int DEPTH    = 4;

  logic       clk       = 1'b0;
  logic       rst       = 1'b1;
  logic       uart_rxd  = 1'b1;
  logic       rx_pop    = 1'b0;
  logic       err_clear = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [2:0] rx_count;
  logic       rx_busy;
  logic       frame_err;
  logic       overrun;
  logic       rx_irq;

  debug_uart_rx #(
    .CLK_HZ     (25_000_000),
    .BIT_RATE   (1_000_000),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .uart_rxd  (uart_rxd),
    .rx_pop    (rx_pop),
    .err_clear (err_clear),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_count  (rx_count),
    .rx_busy   (rx_busy),
    .frame_err (frame_err),
    .overrun   (overrun),
    .rx_irq    (rx_irq)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each transmitted frame schedules its outcome (byte or framing error) at
  // a known edge; the model applies pops, clears and outcomes per edge.
  typedef struct {
    int         edge_no;
    bit         is_err;
    logic [7:0] data;
  } rx_event_t;

  rx_event_t  ev_q[$];
  logic [7:0] m_fifo[$];
  bit         m_fe     = 1'b0;
  bit         m_ov     = 1'b0;
  bit         model_on = 1'b0;
  int         cyc      = 0;

  always @(posedge clk) begin
    bit         push_now;
    bit         err_now;
    logic [7:0] push_byte;
    cyc++;
    push_now  = 1'b0;
    err_now   = 1'b0;
    push_byte = 8'h00;
    if (rst) begin
      m_fifo.delete();
      ev_q.delete();
      m_fe = 1'b0;
      m_ov = 1'b0;
    end else begin
      if (ev_q.size() > 0 && ev_q[0].edge_no == cyc) begin
        if (ev_q[0].is_err) err_now = 1'b1;
        else begin
          push_now  = 1'b1;
          push_byte = ev_q[0].data;
        end
        void'(ev_q.pop_front());
      end
      if (err_clear) begin
        m_fe = 1'b0;
        m_ov = 1'b0;
      end
      if (rx_pop && m_fifo.size() > 0) void'(m_fifo.pop_front());
      if (err_now) m_fe = 1'b1;
      if (push_now) begin
        if (m_fifo.size() < DEPTH) m_fifo.push_back(push_byte);
        else                       m_ov = 1'b1;
      end
    end
  end

  // Per-cycle comparison of all FIFO/flag outputs against the model.
  always @(negedge clk) begin
    logic [7:0] e_data;
    logic       e_valid;
    if (model_on) begin
      e_valid = (m_fifo.size() > 0);
      e_data  = e_valid ? m_fifo[0] : 8'h00;
      check("cycle{valid,count,data,ferr,ovr,irq}",
            {rx_valid, rx_count, rx_data, frame_err, overrun, rx_irq},
            {e_valid, 3'(m_fifo.size()), e_data, m_fe, m_ov, (e_valid | m_fe | m_ov)});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pop_one();
    rx_pop = 1'b1;
    @(posedge clk); #1;
    rx_pop = 1'b0;
  endtask

  task automatic clear_err();
    err_clear = 1'b1;
    @(posedge clk); #1;
    err_clear = 1'b0;
  endtask

  // Sends one frame starting right after the current edge. action: 0 none,
  // 1 pop on the result edge, 2 err_clear on the result edge. A low stop
  // bit leaves the line low on return.
  task automatic send_byte(input logic [7:0] data, input bit stop_val,
                           input int action, input bit probe);
    logic [9:0] frame;
    rx_event_t  ev;
    frame      = {stop_val, data, 1'b0};
    ev.edge_no = cyc + PUSH_LAT;
    ev.is_err  = !stop_val;
    ev.data    = data;
    ev_q.push_back(ev);
    for (int b = 0; b < 9; b++) begin
      uart_rxd = frame[b];
      repeat (CPB) @(posedge clk);
      #1;
    end
    uart_rxd = stop_val;
    repeat (CPB - 11) @(posedge clk);
    #1;
    if (probe) check("probe_valid_before_result_edge", rx_valid, 1'b0);
    if (action == 1) rx_pop    = 1'b1;
    if (action == 2) err_clear = 1'b1;
    @(posedge clk); #1;
    rx_pop    = 1'b0;
    err_clear = 1'b0;
    if (probe) begin
      check("probe_valid_at_240", rx_valid, 1'b1);
      check("probe_data_at_240", rx_data, data);
      check("probe_count_at_240", rx_count, 3'd1);
    end
    repeat (CPB - 15) @(posedge clk);
    #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int busy_cnt;

    repeat (3) @(posedge clk);
    #1;
    rst      = 1'b0;
    model_on = 1'b1;
    check("reset_valid", rx_valid, 1'b0);
    check("reset_count", rx_count, 3'd0);
    check("reset_data", rx_data, 8'h00);
    check("reset_busy", rx_busy, 1'b0);
    check("reset_flags_irq", {frame_err, overrun, rx_irq}, 3'b000);
    idle(5);

    // Single byte, exact result latency, then pop.
    send_byte(8'hA5, 1'b1, 0, 1'b1);
    pop_one();
    check("a5_valid_after_pop", rx_valid, 1'b0);
    check("a5_data_after_pop", rx_data, 8'h00);
    idle(5);

    // 8-cycle glitch: short busy, back to idle, nothing recorded.
    busy_cnt = 0;
    uart_rxd = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (i == 7) uart_rxd = 1'b1;
      if (rx_busy) busy_cnt++;
    end
    check("glitch_busy_within_14", (busy_cnt >= 1 && busy_cnt <= 14), 1'b1);
    check("glitch_busy_end", rx_busy, 1'b0);
    check("glitch_no_flags", {rx_valid, frame_err, overrun}, 3'b000);

    // Framing error followed by a long break: one error only.
    send_byte(8'h3C, 1'b0, 0, 1'b0);
    check("break_frame_err", frame_err, 1'b1);
    check("break_wait_idle_busy", rx_busy, 1'b1);
    check("break_fifo_empty", rx_valid, 1'b0);
    clear_err();
    check("break_err_cleared", frame_err, 1'b0);
    repeat (30 * CPB) @(posedge clk);
    #1;
    check("break_still_waiting", rx_busy, 1'b1);
    check("break_no_second_err", frame_err, 1'b0);
    uart_rxd = 1'b1;
    idle(5);
    check("break_released_idle", rx_busy, 1'b0);
    send_byte(8'h55, 1'b1, 0, 1'b0);
    check("after_break_data", rx_data, 8'h55);
    pop_one();
    idle(3);

    // Five bytes into a four-entry FIFO; clear coincides with the overrun.
    for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b1, 0, 1'b0);
    send_byte(8'h05, 1'b1, 2, 1'b0);
    check("ovr_count", rx_count, 3'd4);
    check("ovr_flag_set_wins", overrun, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      check("ovr_pop_data", rx_data, 32'(i));
      pop_one();
    end
    check("ovr_drained", rx_valid, 1'b0);
    clear_err();
    check("ovr_cleared", overrun, 1'b0);
    idle(3);

    // Full FIFO with a pop on the exact push edge: no overrun.
    send_byte(8'h11, 1'b1, 0, 1'b0);
    send_byte(8'h22, 1'b1, 0, 1'b0);
    send_byte(8'h33, 1'b1, 0, 1'b0);
    send_byte(8'h44, 1'b1, 0, 1'b0);
    send_byte(8'h77, 1'b1, 1, 1'b0);
    check("popsim_count", rx_count, 3'd4);
    check("popsim_no_overrun", overrun, 1'b0);
    check("popsim_data0", rx_data, 8'h22); pop_one();
    check("popsim_data1", rx_data, 8'h33); pop_one();
    check("popsim_data2", rx_data, 8'h44); pop_one();
    check("popsim_data3", rx_data, 8'h77); pop_one();
    check("popsim_empty", rx_valid, 1'b0);
    idle(3);

    // Reset during a data bit of 0xFE, released while the line is high.
    send_byte(8'h42, 1'b1, 0, 1'b0);
    check("pre_rst_valid", rx_valid, 1'b1);
    uart_rxd = 1'b0;
    idle(CPB);
    uart_rxd = 1'b0;
    idle(10);
    check("pre_rst_busy", rx_busy, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_outputs_zero",
          {rx_valid, rx_count, rx_data, rx_busy, frame_err, overrun, rx_irq}, 32'd0);
    idle(14);
    uart_rxd = 1'b1;
    idle(5);
    rst = 1'b0;
    idle(200);
    check("post_rst_no_frame", {rx_valid, rx_busy, frame_err}, 3'b000);
    send_byte(8'h9A, 1'b1, 0, 1'b0);
    check("post_rst_data", rx_data, 8'h9A);
    check("post_rst_count", rx_count, 3'd1);
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
